load_weight_control: RTL

- Read-side counterpart of the output store path.
- Fetches one weight submatrix from the banked weight buffer, one row per cycle, and presents it to the systolic array's weight-load port.
- Generates per-bank read enables and addresses and aligns a valid/row tag with the buffer's fixed read latency.
- Holds done low until the last row has been delivered.

---
 rtl/load_weight_control.sv | 138 +++++++++++++
 1 files changed

// File: rtl/load_weight_control.sv
// Fetches one weight submatrix from the banked weight buffer, one row per cycle,
// and presents it to the systolic array weight-load port aligned to the read latency.
//
// state | meaning
// IDLE  | waiting for start; done high, no reads
// READ  | one row read per cycle across the active banks
// DRAIN | reads finished; waiting RD_LATENCY cycles for the last row to emerge
module load_weight_control #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  output logic                               done,
  input  logic [ADDR_WIDTH-1:0]              rd_base_addr,
  input  logic [$clog2(SYS_ARR_ROWS):0]      num_rows,
  input  logic [$clog2(SYS_ARR_COLS):0]      num_cols,
  output logic [SYS_ARR_COLS-1:0]            rd_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] rd_addr,
  output logic                               weight_valid,
  output logic [$clog2(SYS_ARR_ROWS)-1:0]    weight_row,
  output logic [SYS_ARR_COLS-1:0]            weight_col_mask
);

  localparam int ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int NR_W  = ROW_W + 1;
  localparam int NC_W  = $clog2(SYS_ARR_COLS) + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      count_q, count_d;
  logic [1:0]            drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [NR_W-1:0]       rows_q, rows_d;
  logic [NC_W-1:0]       cols_q, cols_d;

  logic                    vld_pipe_q  [RD_LATENCY];
  logic                    vld_pipe_d  [RD_LATENCY];
  logic [ROW_W-1:0]        row_pipe_q  [RD_LATENCY];
  logic [ROW_W-1:0]        row_pipe_d  [RD_LATENCY];
  logic [SYS_ARR_COLS-1:0] mask_pipe_q [RD_LATENCY];
  logic [SYS_ARR_COLS-1:0] mask_pipe_d [RD_LATENCY];

  logic                    reading;
  logic                    last_row;
  logic [SYS_ARR_COLS-1:0] col_mask;
  logic [ADDR_WIDTH-1:0]   bank_addr;

  assign reading   = (state_q == READ);
  assign last_row  = ({1'b0, count_q} == (rows_q - NR_W'(1)));
  assign col_mask  = {SYS_ARR_COLS{1'b1}} >> (SYS_ARR_COLS - int'(cols_q));
  assign bank_addr = base_q + ADDR_WIDTH'(count_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drain_d = drain_q;
    base_d  = base_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = rd_base_addr;
          rows_d  = num_rows;
          cols_d  = num_cols;
          count_d = '0;
          if ((num_rows != '0) && (num_cols != '0)) state_d = READ;
        end
      end
      READ: begin
        count_d = count_q + ROW_W'(1);
        if (last_row) begin
          state_d = DRAIN;
          drain_d = 2'(RD_LATENCY - 1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = IDLE;
        else                 drain_d = drain_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row tag and mask are forced to zero off-READ so the array sees clean zeros
  // whenever weight_valid is low.
  always_comb begin
    vld_pipe_d[0]  = reading;
    row_pipe_d[0]  = reading ? count_q : '0;
    mask_pipe_d[0] = reading ? col_mask : '0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      row_pipe_d[i]  = row_pipe_q[i-1];
      mask_pipe_d[i] = mask_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      drain_q <= '0;
      base_q  <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= 1'b0;
        row_pipe_q[i]  <= '0;
        mask_pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drain_q <= drain_d;
      base_q  <= base_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_d[i];
        row_pipe_q[i]  <= row_pipe_d[i];
        mask_pipe_q[i] <= mask_pipe_d[i];
      end
    end
  end

  assign done            = (state_q == IDLE);
  assign rd_en           = reading ? col_mask : '0;
  assign rd_addr         = reading ? {SYS_ARR_COLS{bank_addr}} : '0;
  assign weight_valid    = vld_pipe_q[RD_LATENCY-1];
  assign weight_row      = row_pipe_q[RD_LATENCY-1];
  assign weight_col_mask = mask_pipe_q[RD_LATENCY-1];

endmodule
